// File: rtl/btn_input.sv
`default_nettype none
// ============================================================================
// Module   : btn_input
// Brief    : N-channel button conditioner: 2-flop sync, debounce, press/release
//            pulses and auto-repeat step pulses. The release output is named
//            release_pulse because "release" is a reserved word.
// Revision : 1.0 - initial release
// ============================================================================
module btn_input #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 1000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] step
);

    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RPT_W-1:0] c_RD_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RP_LAST  = c_RPT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } rpt_state_t;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_ch
            logic               r_sync1;
            logic               r_sync2;
            logic               r_level;
            logic               r_press;
            logic               r_release;
            logic               r_step;
            logic [c_DB_W-1:0]  r_db_cnt;
            logic [c_RPT_W-1:0] r_rpt_cnt;
            rpt_state_t         r_state;

            logic w_differs;
            logic w_accept;
            logic w_rise;
            logic w_fall;

            assign w_differs = (r_sync2 != r_level);
            assign w_accept  = w_differs && (r_db_cnt == c_DB_LAST);
            assign w_rise    = w_accept && !r_level;
            assign w_fall    = w_accept && r_level;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= btn[g];
                    r_sync2 <= r_sync1;
                end
            end

            // Any cycle where the synchronized value agrees with level restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_db_cnt  <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_press   <= w_rise;
                    r_release <= w_fall;
                    if (!w_differs || w_accept) begin
                        r_db_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                    if (w_accept) begin
                        r_level <= ~r_level;
                    end
                end
            end

            // Release takes priority over an expiring repeat count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state   <= ST_IDLE;
                    r_rpt_cnt <= '0;
                    r_step    <= 1'b0;
                end else begin
                    r_step <= 1'b0;
                    case (r_state)
                        ST_IDLE: begin
                            r_rpt_cnt <= '0;
                            if (w_rise) begin
                                r_step  <= 1'b1;
                                r_state <= ST_DELAY;
                            end
                        end
                        ST_DELAY: begin
                            if (w_fall) begin
                                r_rpt_cnt <= '0;
                                r_state   <= ST_IDLE;
                            end else if (r_rpt_cnt == c_RD_LAST) begin
                                r_step    <= 1'b1;
                                r_rpt_cnt <= '0;
                                r_state   <= ST_REPEAT;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + 1'b1;
                            end
                        end
                        ST_REPEAT: begin
                            if (w_fall) begin
                                r_rpt_cnt <= '0;
                                r_state   <= ST_IDLE;
                            end else if (r_rpt_cnt == c_RP_LAST) begin
                                r_step    <= 1'b1;
                                r_rpt_cnt <= '0;
                            end else begin
                                r_rpt_cnt <= r_rpt_cnt + 1'b1;
                            end
                        end
                        default: begin
                            r_rpt_cnt <= '0;
                            r_state   <= ST_IDLE;
                        end
                    endcase
                end
            end

            assign level[g]         = r_level;
            assign press[g]         = r_press;
            assign release_pulse[g] = r_release;
            assign step[g]          = r_step;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_btn_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_input
// Brief    : Directed bench for btn_input with an edge-history reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_input;

    localparam int N  = 2;
    localparam int DB = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic [N-1:0] btn   = '0;
    logic [N-1:0] level;
    logic [N-1:0] press;
    logic [N-1:0] release_pulse;
    logic [N-1:0] step;

    int n_vec = 0;
    int n_err = 0;

    btn_input #(
        .N               (N),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn           (btn),
        .level         (level),
        .press         (press),
        .release_pulse (release_pulse),
        .step          (step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic tk(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference model: hist[e] is the btn value seen at rising edge e since reset.
    // Level flips at edge e when the synchronized samples of the last DB edges
    // all disagree with it; steps follow arithmetically from the press edge.
    logic [N-1:0] hist [0:8191];
    int           e       = 0;
    logic [N-1:0] m_lvl   = '0;
    logic [N-1:0] m_press = '0;
    logic [N-1:0] m_rel   = '0;
    logic [N-1:0] m_step  = '0;
    int           m_p [N];
    logic         m_all_diff;
    int           m_idx;
    logic         m_v;
    int           m_dt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e       = 0;
            m_lvl   = '0;
            m_press = '0;
            m_rel   = '0;
            m_step  = '0;
        end else begin
            e = e + 1;
            hist[e] = btn;
            for (int c = 0; c < N; c++) begin
                m_all_diff = 1'b1;
                for (int j = 0; j < DB; j++) begin
                    m_idx = e - 2 - j;
                    m_v   = (m_idx >= 1) ? hist[m_idx][c] : 1'b0;
                    if (m_v == m_lvl[c]) m_all_diff = 1'b0;
                end
                m_press[c] = m_all_diff && !m_lvl[c];
                m_rel[c]   = m_all_diff && m_lvl[c];
                if (m_all_diff) m_lvl[c] = ~m_lvl[c];
                if (m_press[c]) m_p[c] = e;
                m_dt = e - m_p[c];
                m_step[c] = m_lvl[c] && ((m_dt == 0) || (m_dt >= RD && ((m_dt - RD) % RP) == 0));
            end
        end
    end

    always @(negedge clk) begin
        chk("model_level",   level,         m_lvl);
        chk("model_press",   press,         m_press);
        chk("model_release", release_pulse, m_rel);
        chk("model_step",    step,          m_step);
    end

    initial begin
        #1 rst_n = 1'b0;
        tk(3);
        chk("reset_level",  level, 2'b00);
        chk("reset_pulses", press | release_pulse | step, 2'b00);
        rst_n = 1'b1;
        tk(1);
        chk("post_reset_quiet", press | release_pulse | step, 2'b00);
        tk(3);

        // Clean press on channel 0, latency and auto-repeat cadence.
        btn = 2'b01;
        tk(5);
        chk("latency_edge5_level", level, 2'b00);
        tk(1);
        chk("latency_level", level, 2'b01);
        chk("latency_press", press, 2'b01);
        chk("latency_step",  step,  2'b01);
        tk(1);
        chk("press_width", press, 2'b00);
        tk(8);
        chk("delay_p9_step", step, 2'b00);
        tk(1);
        chk("delay_p10_step", step, 2'b01);
        tk(3);
        chk("repeat_p13_step", step, 2'b01);

        // Release lands exactly where the repeat count expires (press+31).
        tk(12);
        btn = 2'b00;
        tk(6);
        chk("rel_expire_release", release_pulse, 2'b01);
        chk("rel_expire_step",    step,          2'b00);
        chk("rel_expire_level",   level,         2'b00);
        tk(20);

        // Glitch shorter than the debounce window on channel 1.
        btn = 2'b10;
        tk(3);
        btn = 2'b00;
        tk(10);
        chk("glitch_level", level, 2'b00);

        // Bounce 1,0,1,0 then settle at 1 on channel 0.
        btn = 2'b01; tk(1);
        btn = 2'b00; tk(1);
        btn = 2'b01; tk(1);
        btn = 2'b00; tk(1);
        btn = 2'b01;
        tk(5);
        chk("bounce_edge5_level", level, 2'b00);
        tk(1);
        chk("bounce_press", press, 2'b01);
        chk("bounce_level", level, 2'b01);
        btn = 2'b00;
        tk(12);

        // Simultaneous press on both channels, then reset while in REPEAT.
        btn = 2'b11;
        tk(6);
        chk("dual_press", press, 2'b11);
        chk("dual_step",  step,  2'b11);
        tk(16);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_level",  level, 2'b00);
        chk("async_reset_pulses", press | release_pulse | step, 2'b00);
        tk(1);
        rst_n = 1'b1;
        tk(1);
        chk("deassert_quiet", press | release_pulse | step, 2'b00);
        tk(4);
        chk("rearm_edge5_press", press, 2'b00);
        tk(1);
        chk("rearm_press", press, 2'b11);
        btn = 2'b00;
        tk(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/btn_input.md
BTN_INPUT -- requirements
Module: btn_input

Interface
REQ-001 Parameter N, default 5, number of independent button channels (1..8).
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000, consecutive stable cycles required to accept a change (10 ms at 10 MHz); legal range >= 1.
REQ-003 Parameter REPEAT_DELAY, default 5000000, cycles from press pulse to first auto-repeat step; legal range >= 1.
REQ-004 Parameter REPEAT_PERIOD, default 1000000, cycles between subsequent auto-repeat steps; legal range >= 1.
REQ-005 clk  input  1  system clock (10 MHz DCM output); all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 btn  input  N  raw, asynchronous, bouncing button levels; 1 = pressed.
REQ-008 level  output  N  debounced button level.
REQ-009 press  output  N  one-cycle pulse per channel on accepted 0->1 of level.
REQ-010 release  output  N  one-cycle pulse per channel on accepted 1->0 of level.
REQ-011 step  output  N  one-cycle pulse on press and on each auto-repeat while held.

Function
REQ-012 Each btn bit shall pass a 2-flop synchronizer before any other logic; no raw btn bit shall reach any other logic.
REQ-013 Per channel: debounce counter, width $clog2(DEBOUNCE_CYCLES+1); synchronized value equal to level -> counter cleared.
REQ-014 Synchronized value differing from level -> counter increments; at the edge where counter equals DEBOUNCE_CYCLES-1 and value still differs, level toggles and counter clears.
REQ-015 Latency: input changed and held steady -> level updates on the (DEBOUNCE_CYCLES+2)-th rising edge, counting the first edge that samples the new btn value as edge 1.
REQ-016 Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles shall restart the count and leave level unchanged.
REQ-017 press/release shall be registered and high exactly in the first cycle level shows its new value; never both high on one channel.
REQ-018 Per-channel repeat FSM: states IDLE, DELAY, REPEAT; repeat counter width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
REQ-019 IDLE: accepted press -> step pulses with press, counter cleared, go DELAY.
REQ-020 DELAY: counter increments each cycle; step pulses REPEAT_DELAY cycles after the press pulse; counter cleared, go REPEAT.
REQ-021 REPEAT: step pulses every REPEAT_PERIOD cycles while level stays 1.
REQ-022 Accepted release in DELAY or REPEAT -> IDLE, counter cleared, no step that cycle, even if the repeat count expires simultaneously.
REQ-023 Channels fully independent; simultaneous events on different channels produce simultaneous pulses.
REQ-024 Counters shall saturate/clear, never wrap into spurious pulses.

Reset
REQ-025 rst_n low asynchronously clears synchronizers, counters, level, press, release, step to 0 and all FSMs to IDLE.
REQ-026 Reset asserted mid-press: outputs 0 immediately; after rst_n deasserts, a held button is re-accepted as a fresh press after full debounce latency.
REQ-027 Deassertion is synchronous to clk by system design; no pulse shall occur in the first cycle after deassertion.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, N=2)
REQ-028 btn[0] 0->1 held -> level[0]=1, press[0]=1, step[0]=1 in the same cycle, 6 edges after first sampling edge; press lasts 1 cycle.
REQ-029 btn[0] bounces 1,0,1,0 at 1-cycle intervals then settles 1 -> single press pulse, latency counted from final settling edge.
REQ-030 btn[0] held 30 cycles after press -> step pulses at press+0, +10, +13, +16, +19, ... until release; no pulse after release accepted.
REQ-031 btn[0] released at the cycle the repeat count would expire -> release[0]=1, step[0]=0, FSM IDLE.
REQ-032 rst_n pulsed low while btn[1] held in REPEAT -> all outputs 0 immediately; after deassertion press[1] reappears after 6 edges.
REQ-033 btn[0] and btn[1] pressed on the same edge -> press=2'b11 and step=2'b11 in the same cycle.
